// File: rtl/adder_8bit_pkg.sv
// Shared width constants for the registered 8-bit adder and its lookahead groups.
// Latency: n/a (constants only).
// Backpressure: n/a.
package adder_8bit_pkg;

   // Operand and sum width of the adder.
   localparam int ADDER_W = 8;

   // Width of one carry-lookahead group; the adder is two such groups.
   localparam int CLA_GROUP_W = 4;

endpackage

// File: rtl/adder_8bit_if.sv
// Operand/result bundle for adder_8bit: A/B in, registered Sum/CarryOut out.
// Latency: n/a (wires only); the result trails the operands by one clock.
// Backpressure: none; a new operand pair is accepted every cycle.
interface adder_8bit_if;
   import adder_8bit_pkg::*;

   logic [ADDER_W-1:0] A;
   logic [ADDER_W-1:0] B;
   logic [ADDER_W-1:0] Sum;
   logic               CarryOut;

   // Operand source: drives the addends, observes the result.
   modport master (
      output A,
      output B,
      input  Sum,
      input  CarryOut
   );

   // Adder side: consumes the addends, drives the registered result.
   modport slave (
      input  A,
      input  B,
      output Sum,
      output CarryOut
   );

endinterface

// File: rtl/adder_8bit_cla.sv
// Combinational arithmetic cells: a 1-bit full adder and a 4-bit lookahead group.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.

// Single-bit full adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// 4-bit carry-lookahead group. Each bit's full adder runs with cin tied low so
// that its s output is the propagate term and its cout the generate term; the
// real sum bits are then p ^ carry-in of that bit.
module cla_4bit
   import adder_8bit_pkg::*;
(
   input  logic [CLA_GROUP_W-1:0] a,
   input  logic [CLA_GROUP_W-1:0] b,
   input  logic                   cin,
   output logic [CLA_GROUP_W-1:0] s,
   output logic                   c4
);

   logic [CLA_GROUP_W-1:0] g;
   logic [CLA_GROUP_W-1:0] p;
   logic [CLA_GROUP_W-1:0] c;

   for (genvar i = 0; i < CLA_GROUP_W; i++) begin : g_gp
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (1'b0),
         .s    (p[i]),
         .cout (g[i])
      );
   end

   // Flat lookahead equations: every carry is two gate levels from g/p/cin,
   // so no carry ripples inside the group.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ c;

endmodule

// File: rtl/adder_8bit.sv
// Registered 8-bit unsigned adder: {CarryOut, Sum} = A + B, no carry-in.
// Latency: 1 cycle, outputs straight from flops; synchronous active-low clear wins over capture.
// Backpressure: none; operands are sampled on every rising edge.
module adder_8bit
   import adder_8bit_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   adder_8bit_if.slave   bus
);

   logic [CLA_GROUP_W-1:0] sum_lo;
   logic [CLA_GROUP_W-1:0] sum_hi;
   logic                   c_lo;
   logic                   c_hi;

   logic [ADDER_W-1:0]     sum_q;
   logic                   carry_q;

   // Low group has no carry-in; its group carry feeds the high group.
   cla_4bit u_cla_lo (
      .a   (bus.A[CLA_GROUP_W-1:0]),
      .b   (bus.B[CLA_GROUP_W-1:0]),
      .cin (1'b0),
      .s   (sum_lo),
      .c4  (c_lo)
   );

   cla_4bit u_cla_hi (
      .a   (bus.A[ADDER_W-1:CLA_GROUP_W]),
      .b   (bus.B[ADDER_W-1:CLA_GROUP_W]),
      .cin (c_lo),
      .s   (sum_hi),
      .c4  (c_hi)
   );

   // Capture the 9-bit result each edge; reset forces zeros regardless of A/B.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         sum_q   <= {sum_hi, sum_lo};
         carry_q <= c_hi;
      end
   end

   assign bus.Sum      = sum_q;
   assign bus.CarryOut = carry_q;

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: directed corners, reset cases, random and exhaustive sweeps.
// Latency: expects the result of each operand pair one edge after it is applied.
// Backpressure: none; operands change every cycle.
module tb_adder_8bit;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   adder_8bit_if bus ();

   adder_8bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one operand pair (and reset level) before an edge, then check the
   // registered result just after that edge against plain 9-bit arithmetic.
   task automatic step(input logic [7:0] a, input logic [7:0] b,
                       input logic rst_lvl, input string tag);
      logic [8:0] expected;
      logic [8:0] observed;
      bus.A = a;
      bus.B = b;
      rst_n = rst_lvl;
      if (rst_lvl === 1'b1)
         expected = 9'(int'(a) + int'(b));
      else
         expected = 9'd0;
      @(posedge clk);
      #1;
      observed = {bus.CarryOut, bus.Sum};
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: A=%h B=%h rst_n=%b got carry:sum=%h expected %h",
                tag, a, b, rst_lvl, observed, expected);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.A       = 8'h00;
      bus.B       = 8'h00;
      @(negedge clk);

      // Reset held for two edges with maximal operands, then with X operands.
      step(8'hFF, 8'hFF, 1'b0, "reset_edge1");
      step(8'hFF, 8'hFF, 1'b0, "reset_edge2");
      step(8'hxx, 8'hxx, 1'b0, "reset_x_operands");

      // Directed corners.
      step(8'hCA, 8'h67, 1'b1, "nominal_carry");
      step(8'h00, 8'h00, 1'b1, "zero");
      step(8'h80, 8'h7F, 1'b1, "max_no_carry");
      step(8'hFF, 8'h01, 1'b1, "full_ripple");
      step(8'hFF, 8'hFF, 1'b1, "maximum");
      step(8'h0F, 8'h01, 1'b1, "group_carry");
      step(8'hF0, 8'h10, 1'b1, "high_group_carry");

      // Back-to-back with a one-edge reset in the middle.
      step(8'h12, 8'h34, 1'b1, "b2b_0");
      step(8'hA5, 8'h5A, 1'b1, "b2b_1");
      step(8'hFF, 8'hFF, 1'b0, "midstream_reset");
      step(8'h99, 8'h88, 1'b1, "resume_0");
      step(8'h01, 8'hFE, 1'b1, "resume_1");

      // Random pairs.
      for (int i = 0; i < 1000; i++) begin
         step(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b1, "random");
      end

      // Exhaustive sweep over all operand pairs.
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            step(8'(a), 8'(b), 1'b1, "sweep");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
